// File: rtl/imem_port_ctrl_if.sv
// Bundle between the fetch stage, the boot loader and the
// byte-wide instruction memory macro.
interface imem_port_ctrl_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
);
  logic                     boot_hold;
  logic                     fetch_req_valid;
  logic                     fetch_req_ready;
  logic [ADDRESS_WIDTH-1:0] fetch_addr;
  logic                     fetch_rsp_valid;
  logic [DATA_WIDTH-1:0]    fetch_rsp_instr;
  logic                     load_valid;
  logic                     load_ready;
  logic [ADDRESS_WIDTH-1:0] load_addr;
  logic [BYTE_WIDTH-1:0]    load_byte;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_we;
  logic [BYTE_WIDTH-1:0]    mem_wdata;
  logic [BYTE_WIDTH-1:0]    mem_rdata;
  logic                     busy;

  modport slave (
    input  boot_hold,
    input  fetch_req_valid,
    output fetch_req_ready,
    input  fetch_addr,
    output fetch_rsp_valid,
    output fetch_rsp_instr,
    input  load_valid,
    output load_ready,
    input  load_addr,
    input  load_byte,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output boot_hold,
    output fetch_req_valid,
    input  fetch_req_ready,
    output fetch_addr,
    input  fetch_rsp_valid,
    input  fetch_rsp_instr,
    output load_valid,
    input  load_ready,
    output load_addr,
    output load_byte,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/imem_port_ctrl.sv
// Instruction memory port sequencer: byte-serial 32-bit fetch
// and single-byte loader writes sharing one synchronous memory.
module imem_port_ctrl #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
) (
  input logic         clk,
  input logic         rst_n,
  imem_port_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    RSP,
    WRITE
  } state_t;

  typedef enum logic {
    GRANT_LOAD,
    GRANT_FETCH
  } grant_t;

  localparam int LANE_BITS = DATA_WIDTH - BYTE_WIDTH;

  state_t                   state;
  grant_t                   last_grant;
  logic [1:0]               cnt;
  logic [LANE_BITS-1:0]     lanes;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     we_q;
  logic [BYTE_WIDTH-1:0]    wdata_q;
  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    instr_q;

  logic fetch_elig;
  logic load_elig;
  logic grant_fetch;
  logic grant_load;

  // Round-robin arbitration; only resolved while idle.
  always_comb begin
    fetch_elig  = bus.fetch_req_valid & ~bus.boot_hold;
    load_elig   = bus.load_valid;
    grant_fetch = 1'b0;
    grant_load  = 1'b0;
    if (state == IDLE) begin
      grant_fetch = fetch_elig &
                    (~load_elig | (last_grant == GRANT_LOAD));
      grant_load  = load_elig &
                    (~fetch_elig | (last_grant == GRANT_FETCH));
    end
  end

  // Sequencer: grant, walk four byte reads, assemble, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= GRANT_LOAD;
      cnt         <= 2'd0;
      lanes       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      instr_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= 2'd0;
          unique case (1'b1)
            grant_fetch: begin
              state      <= FETCH;
              last_grant <= GRANT_FETCH;
              addr_q     <= bus.fetch_addr;
              we_q       <= 1'b0;
            end
            grant_load: begin
              state      <= WRITE;
              last_grant <= GRANT_LOAD;
              addr_q     <= bus.load_addr;
              wdata_q    <= bus.load_byte;
              we_q       <= 1'b1;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        FETCH: begin
          // Read data lags the address by one cycle.
          unique case (cnt)
            2'd0: lanes <= lanes;
            2'd1: lanes[BYTE_WIDTH-1:0] <= bus.mem_rdata;
            2'd2: lanes[2*BYTE_WIDTH-1:BYTE_WIDTH] <= bus.mem_rdata;
            default: lanes[3*BYTE_WIDTH-1:2*BYTE_WIDTH] <= bus.mem_rdata;
          endcase
          if (cnt == 2'd3) begin
            state <= DRAIN;
          end else begin
            cnt    <= cnt + 2'd1;
            addr_q <= addr_q + ADDRESS_WIDTH'(1);
          end
        end
        DRAIN: begin
          state       <= RSP;
          cnt         <= 2'd0;
          instr_q     <= {bus.mem_rdata, lanes};
          rsp_valid_q <= 1'b1;
        end
        RSP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        WRITE: begin
          state <= IDLE;
          we_q  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          we_q        <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetch_req_ready = grant_fetch;
  assign bus.load_ready      = grant_load;
  assign bus.fetch_rsp_valid = rsp_valid_q;
  assign bus.fetch_rsp_instr = instr_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_we          = we_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Scoreboard bench for imem_port_ctrl with a behavioural
// byte-wide synchronous memory.
module tb_imem_port_ctrl;

  logic clk;
  logic rst_n;

  imem_port_ctrl_if bus ();

  imem_port_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  // Synchronous-read memory; read returns pre-write contents.
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  int n_cmp;
  int n_bad;
  logic [31:0] sb [$];
  byte exp_grant [$];

  int cyc;
  bit act;
  int gc;
  logic [15:0] ga;
  int we_cnt;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: grant rules, fetch address walk, response check.
  always @(negedge clk) begin
    logic fr;
    logic lr;
    byte g;
    byte seen;
    logic [31:0] e;
    int k;
    cyc++;
    if (!rst_n) begin
      act = 1'b0;
    end else begin
      fr = bus.fetch_req_ready;
      lr = bus.load_ready;
      if (bus.mem_we) we_cnt++;
      if (fr | lr) begin
        n_cmp++;
        if ((fr & lr) | bus.busy | (fr & bus.boot_hold)) begin
          n_bad++;
          $display("FAIL grant_rule: fr=%b lr=%b busy=%b hold=%b",
                   fr, lr, bus.busy, bus.boot_hold);
        end
        seen = fr ? 8'h46 : 8'h4C;
        n_cmp++;
        if (exp_grant.size() == 0) begin
          n_bad++;
          $display("FAIL grant_order: got %c expected none", seen);
        end else begin
          g = exp_grant.pop_front();
          if (g != seen) begin
            n_bad++;
            $display("FAIL grant_order: got %c expected %c", seen, g);
          end
        end
        if (fr) begin
          act = 1'b1;
          gc  = cyc;
          ga  = bus.fetch_addr;
        end
      end
      if (act) begin
        k = cyc - gc;
        if (k >= 1 && k <= 4) begin
          n_cmp++;
          if (bus.mem_addr !== ga + 16'(k - 1) || bus.mem_we) begin
            n_bad++;
            $display("FAIL fetch_addr: got %h we=%b expected %h",
                     bus.mem_addr, bus.mem_we, ga + 16'(k - 1));
          end
        end
      end
      if (bus.fetch_rsp_valid) begin
        n_cmp++;
        if (!act || (cyc - gc) != 6) begin
          n_bad++;
          $display("FAIL rsp_latency: got %0d expected 6",
                   act ? cyc - gc : -1);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_instr: got %h expected none",
                   bus.fetch_rsp_instr);
        end else begin
          e = sb.pop_front();
          if (bus.fetch_rsp_instr !== e) begin
            n_bad++;
            $display("FAIL rsp_instr: got %h expected %h",
                     bus.fetch_rsp_instr, e);
          end
        end
        act = 1'b0;
      end else if (act && (cyc - gc) >= 6) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_missing: got 0 expected 1");
        act = 1'b0;
      end
    end
  end

  task automatic issue_fetch(input logic [15:0] a,
                             input logic [31:0] exp, input bit rsp);
    bit got;
    exp_grant.push_back(8'h46);
    if (rsp) sb.push_back(exp);
    bus.fetch_addr      = a;
    bus.fetch_req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.fetch_req_ready;
      @(posedge clk);
      #1;
    end
    bus.fetch_req_valid = 1'b0;
    chk("fetch_handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic issue_load(input logic [15:0] a, input logic [7:0] d);
    bit got;
    exp_grant.push_back(8'h4C);
    bus.load_addr  = a;
    bus.load_byte  = d;
    bus.load_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.load_ready;
      @(posedge clk);
      #1;
    end
    bus.load_valid = 1'b0;
    chk("load_handshake", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (sb.size() == 0) && !bus.busy && !act;
    end
    chk("drain", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.fetch_rsp_valid), 32'd0);
    chk({tag, "_instr"}, bus.fetch_rsp_instr, 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_fetch_ready"}, 32'(bus.fetch_req_ready), 32'd0);
    chk({tag, "_load_ready"}, 32'(bus.load_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int n;
    bit g;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.boot_hold       = 1'b0;
    bus.fetch_req_valid = 1'b0;
    bus.fetch_addr      = '0;
    bus.load_valid      = 1'b0;
    bus.load_addr       = '0;
    bus.load_byte       = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'hA0;
    mem[3] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue_fetch(16'h0000, 32'h00A00513, 1'b1);
    wait_idle();

    mem[16'hFFFE] = 8'h11;
    mem[16'hFFFF] = 8'h22;
    mem[16'h0000] = 8'h33;
    mem[16'h0001] = 8'h44;
    issue_fetch(16'hFFFE, 32'h44332211, 1'b1);
    wait_idle();

    bus.boot_hold       = 1'b1;
    bus.fetch_addr      = 16'h0010;
    bus.fetch_req_valid = 1'b1;
    w0 = we_cnt;
    issue_load(16'h0010, 8'h93);
    issue_load(16'h0011, 8'h00);
    issue_load(16'h0012, 8'h50);
    issue_load(16'h0013, 8'h00);
    bus.fetch_req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("we_pulses", 32'(we_cnt - w0), 32'd4);
    bus.boot_hold = 1'b0;
    issue_fetch(16'h0010, 32'h00500093, 1'b1);
    wait_idle();

    issue_fetch(16'h0000, 32'h00A04433, 1'b1);
    @(posedge clk);
    #1;
    bus.boot_hold       = 1'b1;
    bus.fetch_addr      = 16'h0010;
    bus.fetch_req_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    bus.boot_hold = 1'b0;
    issue_fetch(16'h0010, 32'h00500093, 1'b1);
    wait_idle();

    issue_fetch(16'h0010, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    exp_grant.push_back(8'h46);
    exp_grant.push_back(8'h4C);
    exp_grant.push_back(8'h46);
    exp_grant.push_back(8'h4C);
    sb.push_back(32'h00A04433);
    sb.push_back(32'h00A04433);
    bus.fetch_addr      = 16'h0000;
    bus.load_addr       = 16'h0100;
    bus.load_byte       = 8'h5A;
    bus.fetch_req_valid = 1'b1;
    bus.load_valid      = 1'b1;
    n = 0;
    for (int i = 0; i < 80 && n < 4; i++) begin
      @(negedge clk);
      g = bus.fetch_req_ready | bus.load_ready;
      @(posedge clk);
      #1;
      if (g) n++;
    end
    bus.fetch_req_valid = 1'b0;
    bus.load_valid      = 1'b0;
    chk("contention_grants", 32'(n), 32'd4);
    wait_idle();

    chk("grant_queue_left", 32'(exp_grant.size()), 32'd0);
    chk("rsp_queue_left", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
